// File: rtl/asip_pkg.sv
// Shared widths, register-class boundary and lane types for the vector ASIP
// writeback path.
package asip_pkg;

  localparam int DATA_W = 4;
  localparam int LANES  = 2;
  localparam int ADDR_W = 4;
  localparam logic [ADDR_W-1:0] VEC_BASE = ADDR_W'(8);
  localparam int CNT_W  = $clog2(LANES) + 1;

  typedef logic [DATA_W-1:0] lane_t;
  typedef lane_t [LANES-1:0] vec_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  function automatic logic is_vector(input logic [ADDR_W-1:0] addr);
    return addr >= VEC_BASE;
  endfunction

endpackage

// File: rtl/load_collector.sv
// Gathers multi-beat load data one lane per beat. It raises a combinational
// done strobe on the final beat and flags protocol violations.
module load_collector
  import asip_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              beat_valid,
  input  lane_t             beat_data,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W-1:0] dest_addr,
  output logic              done,
  output vec_t              done_vec
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  logic [0:0] state;
  cnt_t       count;
  cnt_t       expected;
  vec_t       lanes;
  logic       is_last;

  assign is_last = (count == expected - cnt_t'(1));
  assign done    = (state == COLLECT) && beat_valid && is_last;
  assign busy    = (state == COLLECT);

  // The final beat is merged here so the write can be issued on the same edge.
  always_comb begin
    done_vec = lanes;
    for (int i = 0; i < LANES; i++) begin
      if (count == cnt_t'(i)) done_vec[i] = beat_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      expected  <= '0;
      lanes     <= '0;
      dest_addr <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state     <= COLLECT;
          dest_addr <= start_addr;
          expected  <= is_vector(start_addr) ? cnt_t'(LANES) : cnt_t'(1);
          count     <= '0;
        end
        if (beat_valid) err <= 1'b1;
      end else begin
        if (start) err <= 1'b1;
        if (beat_valid) begin
          for (int i = 0; i < LANES; i++) begin
            if (count == cnt_t'(i)) lanes[i] <= beat_data;
          end
          if (is_last) begin
            state <= IDLE;
            count <= '0;
          end else begin
            count <= count + cnt_t'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage: arbitrates ALU results and assembled loads into one
// registered register-file write per cycle.
module writeback_unit
  import asip_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [ADDR_W-1:0]       alu_addr,
  input  logic [DATA_W-1:0]       alu_sca,
  input  logic [LANES*DATA_W-1:0] alu_vec,
  input  logic                    ld_start,
  input  logic [ADDR_W-1:0]       ld_addr,
  input  logic                    ld_beat_valid,
  input  logic [DATA_W-1:0]       ld_beat_data,
  output logic                    ld_busy,
  output logic                    ld_err,
  output logic                    pending_valid,
  output logic [ADDR_W-1:0]       pending_addr,
  output logic                    WE,
  output logic [ADDR_W-1:0]       A3_WB,
  output logic [DATA_W-1:0]       WD3_SCA,
  output logic [LANES*DATA_W-1:0] WD3_VEC
);

  logic              ld_done;
  vec_t              ld_vec;
  logic [ADDR_W-1:0] ld_dest;
  logic              collecting;
  logic              wr_fire;
  logic [ADDR_W-1:0] wr_addr;
  vec_t              wr_vec;
  lane_t             wr_sca;

  load_collector u_collector (
    .clk        (clk),
    .rst        (rst),
    .start      (ld_start),
    .start_addr (ld_addr),
    .beat_valid (ld_beat_valid),
    .beat_data  (ld_beat_data),
    .busy       (collecting),
    .err        (ld_err),
    .dest_addr  (ld_dest),
    .done       (ld_done),
    .done_vec   (ld_vec)
  );

  assign ld_busy       = collecting;
  assign pending_valid = collecting;
  assign pending_addr  = ld_dest;

  // A completing load owns the write port; the ALU producer must hold its result.
  assign alu_ready = rst && !ld_done;

  always_comb begin
    wr_fire = ld_done || (alu_valid && alu_ready);
    wr_addr = ld_done ? ld_dest : alu_addr;
    wr_vec  = ld_done ? ld_vec : vec_t'(alu_vec);
    wr_sca  = ld_done ? ld_vec[0] : alu_sca;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      WE      <= 1'b0;
      A3_WB   <= '0;
      WD3_SCA <= '0;
      WD3_VEC <= '0;
    end else if (wr_fire) begin
      WE    <= 1'b1;
      A3_WB <= wr_addr;
      if (is_vector(wr_addr)) begin
        WD3_SCA <= '0;
        WD3_VEC <= wr_vec;
      end else begin
        WD3_SCA <= wr_sca;
        WD3_VEC <= '0;
      end
    end else begin
      WE <= 1'b0;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed scenario bench for writeback_unit with hand-computed expectations.
module tb_writeback_unit;

  logic       clk;
  logic       rst;
  logic       alu_valid;
  logic       alu_ready;
  logic [3:0] alu_addr;
  logic [3:0] alu_sca;
  logic [7:0] alu_vec;
  logic       ld_start;
  logic [3:0] ld_addr;
  logic       ld_beat_valid;
  logic [3:0] ld_beat_data;
  logic       ld_busy;
  logic       ld_err;
  logic       pending_valid;
  logic [3:0] pending_addr;
  logic       WE;
  logic [3:0] A3_WB;
  logic [3:0] WD3_SCA;
  logic [7:0] WD3_VEC;

  int checks;
  int passed;

  writeback_unit dut (
    .clk           (clk),
    .rst           (rst),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_addr      (alu_addr),
    .alu_sca       (alu_sca),
    .alu_vec       (alu_vec),
    .ld_start      (ld_start),
    .ld_addr       (ld_addr),
    .ld_beat_valid (ld_beat_valid),
    .ld_beat_data  (ld_beat_data),
    .ld_busy       (ld_busy),
    .ld_err        (ld_err),
    .pending_valid (pending_valid),
    .pending_addr  (pending_addr),
    .WE            (WE),
    .A3_WB         (A3_WB),
    .WD3_SCA       (WD3_SCA),
    .WD3_VEC       (WD3_VEC)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    alu_valid = 1'b0; alu_addr = 4'd0; alu_sca = 4'd0; alu_vec = 8'd0;
    ld_start = 1'b0; ld_addr = 4'd0; ld_beat_valid = 1'b0; ld_beat_data = 4'd0;
    #2 rst = 1'b0;
    #1;
    checks++; if (WE !== 1'b0) $display("[TB] FAIL reset_we got %b want 0", WE); else passed++;
    checks++; if (A3_WB !== 4'd0) $display("[TB] FAIL reset_a3 got %h want 0", A3_WB); else passed++;
    checks++; if (WD3_SCA !== 4'd0) $display("[TB] FAIL reset_sca got %h want 0", WD3_SCA); else passed++;
    checks++; if (WD3_VEC !== 8'd0) $display("[TB] FAIL reset_vec got %h want 0", WD3_VEC); else passed++;
    checks++; if (ld_busy !== 1'b0 || pending_valid !== 1'b0 || ld_err !== 1'b0)
      $display("[TB] FAIL reset_ld got busy=%b pend=%b err=%b want 0/0/0", ld_busy, pending_valid, ld_err); else passed++;
    checks++; if (alu_ready !== 1'b0) $display("[TB] FAIL reset_ready got %b want 0", alu_ready); else passed++;
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++; if (alu_ready !== 1'b1) $display("[TB] FAIL idle_ready got %b want 1", alu_ready); else passed++;
  endtask

  task automatic test_alu_scalar();
    alu_valid = 1'b1; alu_addr = 4'd1; alu_sca = 4'b1111; alu_vec = 8'hAB;
    tick();
    alu_valid = 1'b0;
    checks++; if (WE !== 1'b1) $display("[TB] FAIL alu_sca_we got %b want 1", WE); else passed++;
    checks++; if (A3_WB !== 4'd1) $display("[TB] FAIL alu_sca_a3 got %h want 1", A3_WB); else passed++;
    checks++; if (WD3_SCA !== 4'hF) $display("[TB] FAIL alu_sca_data got %h want f", WD3_SCA); else passed++;
    checks++; if (WD3_VEC !== 8'h00) $display("[TB] FAIL alu_sca_vecgate got %h want 00", WD3_VEC); else passed++;
    tick();
    checks++; if (WE !== 1'b0) $display("[TB] FAIL alu_sca_pulse got %b want 0", WE); else passed++;
    checks++; if (A3_WB !== 4'd1 || WD3_SCA !== 4'hF) $display("[TB] FAIL alu_sca_hold got a3=%h sca=%h want 1/f", A3_WB, WD3_SCA); else passed++;
  endtask

  task automatic test_alu_vector();
    alu_valid = 1'b1; alu_addr = 4'd8; alu_sca = 4'h5; alu_vec = {4'b1100, 4'b1010};
    tick();
    alu_valid = 1'b0;
    checks++; if (WE !== 1'b1 || A3_WB !== 4'd8) $display("[TB] FAIL alu_vec_we got we=%b a3=%h want 1/8", WE, A3_WB); else passed++;
    checks++; if (WD3_VEC !== 8'hCA) $display("[TB] FAIL alu_vec_data got %h want ca", WD3_VEC); else passed++;
    checks++; if (WD3_SCA !== 4'h0) $display("[TB] FAIL alu_vec_scagate got %h want 0", WD3_SCA); else passed++;
    tick();
  endtask

  task automatic test_vector_load();
    ld_start = 1'b1; ld_addr = 4'd9;
    tick();
    ld_start = 1'b0;
    checks++; if (ld_busy !== 1'b1 || pending_valid !== 1'b1) $display("[TB] FAIL vld_pending got busy=%b pend=%b want 1/1", ld_busy, pending_valid); else passed++;
    checks++; if (pending_addr !== 4'd9) $display("[TB] FAIL vld_paddr got %h want 9", pending_addr); else passed++;
    ld_beat_valid = 1'b1; ld_beat_data = 4'b1010;
    tick();
    checks++; if (WE !== 1'b0 || pending_valid !== 1'b1) $display("[TB] FAIL vld_mid got we=%b pend=%b want 0/1", WE, pending_valid); else passed++;
    ld_beat_data = 4'b1100;
    #1;
    checks++; if (alu_ready !== 1'b0) $display("[TB] FAIL vld_final_ready got %b want 0", alu_ready); else passed++;
    tick();
    ld_beat_valid = 1'b0;
    checks++; if (WE !== 1'b1 || A3_WB !== 4'd9) $display("[TB] FAIL vld_we got we=%b a3=%h want 1/9", WE, A3_WB); else passed++;
    checks++; if (WD3_VEC !== 8'hCA || WD3_SCA !== 4'h0) $display("[TB] FAIL vld_data got vec=%h sca=%h want ca/0", WD3_VEC, WD3_SCA); else passed++;
    checks++; if (pending_valid !== 1'b0 || ld_busy !== 1'b0) $display("[TB] FAIL vld_drop got pend=%b busy=%b want 0/0", pending_valid, ld_busy); else passed++;
    tick();
  endtask

  task automatic test_collision();
    ld_start = 1'b1; ld_addr = 4'd10;
    tick();
    ld_start = 1'b0;
    ld_beat_valid = 1'b1; ld_beat_data = 4'h3;
    tick();
    ld_beat_data = 4'h4;
    alu_valid = 1'b1; alu_addr = 4'd3; alu_sca = 4'h7; alu_vec = 8'hEE;
    #1;
    checks++; if (alu_ready !== 1'b0) $display("[TB] FAIL coll_stall got %b want 0", alu_ready); else passed++;
    tick();
    ld_beat_valid = 1'b0;
    checks++; if (WE !== 1'b1 || A3_WB !== 4'd10 || WD3_VEC !== 8'h43)
      $display("[TB] FAIL coll_load got we=%b a3=%h vec=%h want 1/a/43", WE, A3_WB, WD3_VEC); else passed++;
    #1;
    checks++; if (alu_ready !== 1'b1) $display("[TB] FAIL coll_ready got %b want 1", alu_ready); else passed++;
    tick();
    alu_valid = 1'b0;
    checks++; if (WE !== 1'b1 || A3_WB !== 4'd3 || WD3_SCA !== 4'h7 || WD3_VEC !== 8'h00)
      $display("[TB] FAIL coll_alu got we=%b a3=%h sca=%h vec=%h want 1/3/7/00", WE, A3_WB, WD3_SCA, WD3_VEC); else passed++;
    tick();
    checks++; if (WE !== 1'b0) $display("[TB] FAIL coll_idle got %b want 0", WE); else passed++;
  endtask

  task automatic test_scalar_load();
    ld_start = 1'b1; ld_addr = 4'd5;
    tick();
    ld_start = 1'b0;
    ld_beat_valid = 1'b1; ld_beat_data = 4'b0110;
    tick();
    ld_beat_valid = 1'b0;
    checks++; if (WE !== 1'b1 || A3_WB !== 4'd5) $display("[TB] FAIL sld_we got we=%b a3=%h want 1/5", WE, A3_WB); else passed++;
    checks++; if (WD3_SCA !== 4'b0110 || WD3_VEC !== 8'h00) $display("[TB] FAIL sld_data got sca=%h vec=%h want 6/00", WD3_SCA, WD3_VEC); else passed++;
    checks++; if (pending_valid !== 1'b0) $display("[TB] FAIL sld_drop got %b want 0", pending_valid); else passed++;
    tick();
  endtask

  task automatic test_errors();
    ld_beat_valid = 1'b1; ld_beat_data = 4'h9;
    tick();
    ld_beat_valid = 1'b0;
    checks++; if (ld_err !== 1'b1) $display("[TB] FAIL err_idle_beat got %b want 1", ld_err); else passed++;
    checks++; if (WE !== 1'b0 || ld_busy !== 1'b0) $display("[TB] FAIL err_idle_nowr got we=%b busy=%b want 0/0", WE, ld_busy); else passed++;
    tick();
    checks++; if (ld_err !== 1'b0) $display("[TB] FAIL err_pulse got %b want 0", ld_err); else passed++;
    ld_start = 1'b1; ld_addr = 4'd12;
    tick();
    ld_addr = 4'd2;
    tick();
    ld_start = 1'b0;
    checks++; if (ld_err !== 1'b1 || pending_addr !== 4'd12 || ld_busy !== 1'b1)
      $display("[TB] FAIL err_restart got err=%b paddr=%h busy=%b want 1/c/1", ld_err, pending_addr, ld_busy); else passed++;
    ld_beat_valid = 1'b1; ld_beat_data = 4'h1;
    tick();
    ld_beat_data = 4'h2;
    tick();
    ld_beat_valid = 1'b0;
    checks++; if (WE !== 1'b1 || A3_WB !== 4'd12 || WD3_VEC !== 8'h21)
      $display("[TB] FAIL err_continue got we=%b a3=%h vec=%h want 1/c/21", WE, A3_WB, WD3_VEC); else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    ld_start = 1'b1; ld_addr = 4'd11;
    tick();
    ld_start = 1'b0;
    ld_beat_valid = 1'b1; ld_beat_data = 4'h5;
    tick();
    ld_beat_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (WE !== 1'b0 || A3_WB !== 4'd0 || WD3_SCA !== 4'd0 || WD3_VEC !== 8'd0)
      $display("[TB] FAIL rmid_out got we=%b a3=%h sca=%h vec=%h want 0/0/0/00", WE, A3_WB, WD3_SCA, WD3_VEC); else passed++;
    checks++; if (pending_valid !== 1'b0 || ld_busy !== 1'b0 || pending_addr !== 4'd0)
      $display("[TB] FAIL rmid_pend got pend=%b busy=%b paddr=%h want 0/0/0", pending_valid, ld_busy, pending_addr); else passed++;
    #1 rst = 1'b1;
    tick();
    ld_beat_valid = 1'b1; ld_beat_data = 4'h6;
    tick();
    ld_beat_valid = 1'b0;
    checks++; if (WE !== 1'b0 || ld_err !== 1'b1) $display("[TB] FAIL rmid_nowr got we=%b err=%b want 0/1", WE, ld_err); else passed++;
    tick();
    checks++; if (WE !== 1'b0) $display("[TB] FAIL rmid_late got %b want 0", WE); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_alu_scalar();
    test_alu_vector();
    test_vector_load();
    test_collision();
    test_scalar_load();
    test_errors();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
